// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared encodings and constants for the instruction-memory fetch controller
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_LOAD  = 1'b1
    } grant_t;

    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam int          BYTES_PER_INST = 4;

endpackage

// File: rtl/imem_rr_arb2.sv
// rtl/imem_rr_arb2.sv - two-requester round-robin arbiter (fetch vs. loader)
module imem_rr_arb2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_fetch,
    input  logic req_load,
    output logic gnt_fetch,
    output logic gnt_load
);

    grant_t last_grant;

    // On a tie the port that did not win last time is served.
    always_comb begin
        gnt_fetch = en && req_fetch && (!req_load || last_grant == GNT_LOAD);
        gnt_load  = en && req_load  && (!req_fetch || last_grant == GNT_FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_LOAD;
        end else if (gnt_fetch) begin
            last_grant <= GNT_FETCH;
        end else if (gnt_load) begin
            last_grant <= GNT_LOAD;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - byte-wide instruction memory sequencer: 32-bit fetches as four byte reads, plus loader writes
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic [63:0]   fetch_addr,
    output logic          fetch_ready,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic          fetch_err,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata
);

    localparam logic [63:0] MAX_ADDR = 64'(DEPTH - BYTES_PER_INST);

    state_t        state, state_nxt;
    logic [AW-1:0] base;
    logic [1:0]    cnt;
    logic          err;
    logic [23:0]   buf_q;
    logic [31:0]   inst_q;
    logic          idle;
    logic          gnt_fetch, gnt_load;
    logic          addr_bad;

    // Grants are suppressed while reset is held so no ready leaks out.
    assign idle     = (state == IDLE) && !reset;
    assign addr_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr > MAX_ADDR);

    imem_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (idle),
        .req_fetch (fetch_req),
        .req_load  (load_valid),
        .gnt_fetch (gnt_fetch),
        .gnt_load  (gnt_load)
    );

    always_comb begin
        state_nxt   = state;
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        inst_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_load) begin
                    load_ready = 1'b1;
                    mem_we     = 1'b1;
                    mem_addr   = load_addr;
                    mem_wdata  = load_data;
                end else if (gnt_fetch) begin
                    fetch_ready = 1'b1;
                    state_nxt   = addr_bad ? DONE : READ;
                end
            end
            READ: begin
                mem_addr = base + AW'(cnt);
                if (cnt == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                inst_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            base   <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            buf_q  <= '0;
            inst_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_fetch) begin
                base <= fetch_addr[AW-1:0];
                cnt  <= '0;
                err  <= addr_bad;
                if (addr_bad) begin
                    inst_q <= NOP_INST;
                end
            end else if (state == READ) begin
                cnt <= cnt + 2'd1;
                // Lane 3 goes straight into the instruction so it only changes on entry to DONE.
                case (cnt)
                    2'd0: buf_q[7:0]   <= mem_rdata;
                    2'd1: buf_q[15:8]  <= mem_rdata;
                    2'd2: buf_q[23:16] <= mem_rdata;
                    default: inst_q    <= {mem_rdata, buf_q};
                endcase
            end
        end
    end

    assign inst      = inst_q;
    assign fetch_err = err;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer and arbiter for the byte-wide instruction memory. Serves 32-bit instruction fetches from the core by issuing four sequential byte reads, and lets a program-loader port write bytes into the same memory. Requests are round-robin arbitrated while the controller is idle. Sits between the PC/fetch stage and the single-port byte array that holds the program.

## Interface
- DEPTH, 16, memory size in bytes; must be a power of two and ≥ 4.
- AW, 4, byte address width; equals log2(DEPTH).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  64  byte address of the instruction.
- fetch_ready  out  1  fetch accepted this cycle.
- inst_valid  out  1  one-cycle pulse; `inst` and `fetch_err` are valid.
- inst  out  32  assembled instruction, little-endian.
- fetch_err  out  1  the fetch was misaligned or out of range.
- load_valid  in  1  loader byte-write request.
- load_addr  in  AW  loader byte address.
- load_data  in  8  loader byte.
- load_ready  out  1  loader write performed this cycle.
- mem_addr  out  AW  memory byte address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  8  memory read data, combinational from `mem_addr`.

## Operation
- States: IDLE, READ, DONE.
- **IDLE:**
  - Grant goes to at most one of fetch and load.
  - If only one requests, it is granted.
  - If both request, grant goes to the port not granted last (`last_grant` register).
- **Load grant (IDLE):**
  - `load_ready`=1, `mem_we`=1, `mem_addr`=`load_addr`, `mem_wdata`=`load_data`, all combinational in the same cycle.
  - State stays IDLE; `last_grant` becomes LOAD.
- **Fetch grant (IDLE):**
  - `fetch_ready`=1 combinationally.
  - At the edge: latch `fetch_addr[AW-1:0]` as `base`, clear `cnt`, set `last_grant` to FETCH.
  - If `fetch_addr[1:0]`≠0, or `fetch_addr` > DEPTH-4 (full 64-bit compare), set `err`=1 and go to DONE.
  - Otherwise set `err`=0 and go to READ.
- **READ:**
  - `mem_addr`=`base`+`cnt`, `mem_we`=0.
  - Each edge captures `mem_rdata` into byte lane `cnt` of the shift buffer and increments `cnt` (2 bits).
  - On the edge with `cnt`=3, go to DONE.
  - The range check guarantees no address wrap.
- **DONE:**
  - `inst_valid`=1 for one cycle.
  - `inst` = {b3,b2,b1,b0}, or 32'h00000013 (NOP) if `err`.
  - `fetch_err`=`err`.
  - Next edge returns to IDLE.
- `fetch_ready` and `load_ready` are 0 outside IDLE; requests must be held until their ready is seen.
- `inst` holds its last value until the next DONE.
- There is no consumer backpressure.

## Timing
- **Reset (asynchronous, immediate):**
  - State IDLE, `cnt`=0, `last_grant`=LOAD (fetch wins the first tie).
  - `inst`=0, `inst_valid`=0, `fetch_err`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `fetch_ready`=0 and `load_ready`=0 while `reset`=1.
- **Fetch latency:**
  - Acceptance edge E0; READ covers the cycles after E0..E3.
  - `inst_valid` is high between E4 and E5.
  - The next fetch can be accepted in the cycle after E5, giving a throughput of one instruction per 6 cycles.
- **Error fetch:** `inst_valid` is high between E1 and E2.
- **Load:** one byte per cycle, back-to-back, when no fetch is competing.
- **Reset mid-READ:** the partial instruction is discarded, no `inst_valid` is produced, and `inst` returns to 0.
- **Load during a fetch:** stalls (`load_ready`=0) until IDLE, then wins the tie because `last_grant`=FETCH.

## Structure
- Shared package `imem_pkg`:
  - state encoding (IDLE=2'd0, READ=2'd1, DONE=2'd2);
  - grant encoding (FETCH/LOAD);
  - `NOP_INST` = 32'h00000013;
  - `BYTES_PER_INST` = 4.
- One sub-module: `imem_rr_arb2`, a two-requester round-robin arbiter with a `last_grant` register, updated on grant and reset to LOAD.

## Test plan
- Bench memory model is preloaded with bytes 83 34 85 02 B3 84 9A 00 93 84 14 00 23 34 95 02.
- Fetch `addr`=0 → `inst_valid` 4 edges after acceptance, `inst`=32'h02853483, `fetch_err`=0; then `addr`=12 → 32'h02953423.
- Fetch `addr`=6 → `inst_valid` 1 edge after acceptance, `inst`=32'h00000013, `fetch_err`=1, no READ cycles. Fetch `addr`=64'h100 → same response.
- Load `addr`=4, `data`=8'hEF, then fetch `addr`=4 → `inst`=32'h009A84EF; `mem_we` high for exactly 1 cycle.
- `fetch_req` and `load_valid` asserted together from reset → fetch granted first; load granted in the first IDLE cycle after DONE; the next tie goes to fetch.
- Assert `reset` after 2 READ edges → outputs return to reset values immediately, no `inst_valid` pulse; a fresh fetch of `addr`=8 → 32'h00148493.
